// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, opcodes,
// ALU function codes, branch selects and the packed control vector.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;
    localparam logic [5:0] OP_ANDI  = 6'h02;
    localparam logic [5:0] OP_ORI   = 6'h03;
    localparam logic [5:0] OP_LD    = 6'h04;
    localparam logic [5:0] OP_ST    = 6'h05;
    localparam logic [5:0] OP_MOVE  = 6'h06;
    localparam logic [5:0] OP_BZ    = 6'h09;
    localparam logic [5:0] OP_BLTZ  = 6'h0A;
    localparam logic [5:0] OP_BGTZ  = 6'h0B;
    localparam logic [5:0] OP_JUMP  = 6'h0C;
    localparam logic [5:0] OP_CALL  = 6'h0D;
    localparam logic [5:0] OP_RET   = 6'h0E;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SLA = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_ZERO = 2'b01;
    localparam logic [1:0] BR_NEG  = 2'b10;
    localparam logic [1:0] BR_POS  = 2'b11;

    typedef struct packed {
        logic       PCUpdate;
        logic       regDest;
        logic       writeSP;
        logic       readSP;
        logic       updateSP;
        logic       writeReg;
        logic       aluSource;
        logic       PM4;
        logic       retMem;
        logic       memRead;
        logic       memWrite;
        logic       memReg;
        logic       spmux;
        logic       moveReg;
        logic       jump;
        logic       retPC;
        logic       haltPC;
        logic [1:0] branch;
        logic [3:0] aluOp;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control table: maps (state, latched opcode, latched func)
// onto the full datapath control vector.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opQ,
    input  logic [3:0] funcQ,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_EXEC: begin
                case (opQ)
                    OP_RTYPE: ctrl.aluOp = funcQ;
                    OP_ADDI: begin ctrl.aluSource = 1'b1; ctrl.aluOp = ALU_ADD; end
                    OP_ANDI: begin ctrl.aluSource = 1'b1; ctrl.aluOp = ALU_AND; end
                    OP_ORI:  begin ctrl.aluSource = 1'b1; ctrl.aluOp = ALU_OR;  end
                    OP_LD, OP_ST: begin
                        ctrl.aluSource = 1'b1;
                        ctrl.aluOp     = ALU_ADD;
                    end
                    OP_BZ:   ctrl.branch = BR_ZERO;
                    OP_BLTZ: ctrl.branch = BR_NEG;
                    OP_BGTZ: ctrl.branch = BR_POS;
                    // CALL pre-decrements the stack pointer, RET post-increments it
                    OP_CALL: begin
                        ctrl.readSP = 1'b1;
                        ctrl.spmux  = 1'b1;
                        ctrl.PM4    = 1'b1;
                        ctrl.aluOp  = ALU_ADD;
                    end
                    OP_RET: begin
                        ctrl.readSP = 1'b1;
                        ctrl.spmux  = 1'b1;
                        ctrl.aluOp  = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                case (opQ)
                    OP_LD, OP_RET: ctrl.memRead = 1'b1;
                    OP_ST:         ctrl.memWrite = 1'b1;
                    OP_CALL: begin
                        ctrl.retMem   = 1'b1;
                        ctrl.updateSP = 1'b1;
                        ctrl.memWrite = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                ctrl.PCUpdate = 1'b1;
                case (opQ)
                    OP_RTYPE: begin ctrl.regDest = 1'b1; ctrl.writeReg = 1'b1; end
                    OP_ADDI, OP_ANDI, OP_ORI: ctrl.writeReg = 1'b1;
                    OP_LD: begin ctrl.memReg = 1'b1; ctrl.writeReg = 1'b1; end
                    OP_MOVE: begin
                        ctrl.moveReg  = 1'b1;
                        ctrl.regDest  = 1'b1;
                        ctrl.writeReg = 1'b1;
                    end
                    OP_JUMP: ctrl.jump = 1'b1;
                    OP_CALL: begin ctrl.writeSP = 1'b1; ctrl.jump = 1'b1; end
                    OP_RET: begin
                        ctrl.memReg  = 1'b1;
                        ctrl.retPC   = 1'b1;
                        ctrl.writeSP = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT:  ctrl.haltPC = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle processor controller: FETCH/DECODE/EXEC/MEM/WB sequencer with
// opcode latch, halt detection and a retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] HALT_OP = OP_HALT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    output logic             PCUpdate,
    output logic             regDest,
    output logic             writeSP,
    output logic             readSP,
    output logic             updateSP,
    output logic             writeReg,
    output logic             aluSource,
    output logic             PM4,
    output logic             spmmux,
    output logic             retMem,
    output logic             memRead,
    output logic             memWrite,
    output logic             memReg,
    output logic             spmux,
    output logic             moveReg,
    output logic             jump,
    output logic             retPC,
    output logic             haltPC,
    output logic [1:0]       branch,
    output logic [3:0]       aluOp,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t     state, nextState;
    logic [5:0] opQ;
    logic [3:0] funcQ;
    ctrl_t      ctrl;
    logic       unusedInstrBits;

    assign unusedInstrBits = ^instr[25:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            S_FETCH:  nextState = S_DECODE;
            S_DECODE: nextState = (instr[31:26] == HALT_OP) ? S_HALT : S_EXEC;
            S_EXEC:   nextState = S_MEM;
            S_MEM:    nextState = S_WB;
            S_WB:     nextState = S_FETCH;
            S_HALT:   nextState = S_HALT;
            default:  nextState = S_FETCH;
        endcase
    end

    // Later stages see only the latched fields, so instr may change after DECODE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opQ   <= '0;
            funcQ <= '0;
        end else if (state == S_DECODE) begin
            opQ   <= instr[31:26];
            funcQ <= instr[3:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               retired <= '0;
        else if (state == S_WB)  retired <= retired + CNT_W'(1);
    end

    ctrl_decode uDecode (
        .state (state),
        .opQ   (opQ),
        .funcQ (funcQ),
        .ctrl  (ctrl)
    );

    assign PCUpdate  = ctrl.PCUpdate;
    assign regDest   = ctrl.regDest;
    assign writeSP   = ctrl.writeSP;
    assign readSP    = ctrl.readSP;
    assign updateSP  = ctrl.updateSP;
    assign writeReg  = ctrl.writeReg;
    assign aluSource = ctrl.aluSource;
    assign PM4       = ctrl.PM4;
    assign spmmux    = 1'b0;
    assign retMem    = ctrl.retMem;
    assign memRead   = ctrl.memRead;
    assign memWrite  = ctrl.memWrite;
    assign memReg    = ctrl.memReg;
    assign spmux     = ctrl.spmux;
    assign moveReg   = ctrl.moveReg;
    assign jump      = ctrl.jump;
    assign retPC     = ctrl.retPC;
    assign haltPC    = ctrl.haltPC;
    assign branch    = ctrl.branch;
    assign aluOp     = ctrl.aluOp;
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, randomized
// instructions against a per-cycle reference model, reset and halt sequences.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic PCUpdate, regDest, writeSP, readSP, updateSP, writeReg, aluSource, PM4;
    logic spmmux, retMem, memRead, memWrite, memReg, spmux, moveReg, jump, retPC, haltPC;
    logic [1:0]  branch;
    logic [3:0]  aluOp;
    logic        halted;
    logic [31:0] retired;

    multicycle_ctrl #(.CNT_W(32), .HALT_OP(6'h3F)) dut (
        .clk(clk), .reset(reset), .instr(instr),
        .PCUpdate(PCUpdate), .regDest(regDest), .writeSP(writeSP), .readSP(readSP),
        .updateSP(updateSP), .writeReg(writeReg), .aluSource(aluSource), .PM4(PM4),
        .spmmux(spmmux), .retMem(retMem), .memRead(memRead), .memWrite(memWrite),
        .memReg(memReg), .spmux(spmux), .moveReg(moveReg), .jump(jump), .retPC(retPC),
        .haltPC(haltPC), .branch(branch), .aluOp(aluOp), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [23:0] M_PCU      = 24'h800000;
    localparam logic [23:0] M_REGDEST  = 24'h400000;
    localparam logic [23:0] M_WRITESP  = 24'h200000;
    localparam logic [23:0] M_READSP   = 24'h100000;
    localparam logic [23:0] M_UPDATESP = 24'h080000;
    localparam logic [23:0] M_WRITEREG = 24'h040000;
    localparam logic [23:0] M_ALUSRC   = 24'h020000;
    localparam logic [23:0] M_PM4      = 24'h010000;
    localparam logic [23:0] M_RETMEM   = 24'h004000;
    localparam logic [23:0] M_MEMREAD  = 24'h002000;
    localparam logic [23:0] M_MEMWRITE = 24'h001000;
    localparam logic [23:0] M_MEMREG   = 24'h000800;
    localparam logic [23:0] M_SPMUX    = 24'h000400;
    localparam logic [23:0] M_MOVEREG  = 24'h000200;
    localparam logic [23:0] M_JUMP     = 24'h000100;
    localparam logic [23:0] M_RETPC    = 24'h000080;
    localparam logic [23:0] M_HALTPC   = 24'h000040;

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  func;
        logic [23:0] expExec;
        logic [23:0] expMem;
        logic [23:0] expWb;
    } vec_t;

    vec_t        vecs[15];
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] retiredModel = 0;
    logic [5:0]  knownOps[14] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                  6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h20};

    function automatic logic [23:0] ctrlVec();
        return {PCUpdate, regDest, writeSP, readSP, updateSP, writeReg, aluSource, PM4,
                spmmux, retMem, memRead, memWrite, memReg, spmux, moveReg, jump, retPC,
                haltPC, branch, aluOp};
    endfunction

    // Expected controls for cycle "phase" (0..4) of one instruction
    function automatic logic [23:0] refCtrl(int phase, logic [5:0] op, logic [3:0] func);
        logic [23:0] v;
        bit exec, mem, wb;
        v    = 24'h0;
        exec = (phase == 2);
        mem  = (phase == 3);
        wb   = (phase == 4);
        if (wb) v |= M_PCU;
        case (op)
            6'h00: begin
                if (exec) v |= {20'h0, func};
                if (wb)   v |= M_REGDEST | M_WRITEREG;
            end
            6'h01, 6'h02, 6'h03: begin
                if (exec) v |= M_ALUSRC | ((op == 6'h01) ? 24'd0 : (op == 6'h02) ? 24'd2 : 24'd3);
                if (wb)   v |= M_WRITEREG;
            end
            6'h04: begin
                if (exec) v |= M_ALUSRC;
                if (mem)  v |= M_MEMREAD;
                if (wb)   v |= M_MEMREG | M_WRITEREG;
            end
            6'h05: begin
                if (exec) v |= M_ALUSRC;
                if (mem)  v |= M_MEMWRITE;
            end
            6'h06: if (wb) v |= M_MOVEREG | M_REGDEST | M_WRITEREG;
            6'h09: if (exec) v |= 24'h10;
            6'h0A: if (exec) v |= 24'h20;
            6'h0B: if (exec) v |= 24'h30;
            6'h0C: if (wb) v |= M_JUMP;
            6'h0D: begin
                if (exec) v |= M_READSP | M_SPMUX | M_PM4;
                if (mem)  v |= M_RETMEM | M_UPDATESP | M_MEMWRITE;
                if (wb)   v |= M_WRITESP | M_JUMP;
            end
            6'h0E: begin
                if (exec) v |= M_READSP | M_SPMUX;
                if (mem)  v |= M_MEMREAD;
                if (wb)   v |= M_MEMREG | M_RETPC | M_WRITESP;
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Runs one full instruction starting in FETCH and checks every cycle
    task automatic applyStimulus(input logic [5:0] op, input logic [3:0] func,
                                 input logic [23:0] eExec, input logic [23:0] eMem,
                                 input logic [23:0] eWb, input string tag);
        logic [23:0] exp;
        instr = {op, 22'($urandom), func};
        for (int p = 0; p < 5; p++) begin
            exp = (p == 2) ? eExec : (p == 3) ? eMem : (p == 4) ? eWb : 24'h0;
            checkOutput($sformatf("%s ph%0d ctrl", tag, p), {8'h0, ctrlVec()}, {8'h0, exp});
            checkOutput($sformatf("%s ph%0d halted", tag, p), {31'h0, halted}, 32'h0);
            step();
        end
        retiredModel = retiredModel + 1;
        checkOutput($sformatf("%s retired", tag), retired, retiredModel);
    endtask

    task automatic runModel(input logic [5:0] op, input logic [3:0] func, input string tag);
        applyStimulus(op, func, refCtrl(2, op, func), refCtrl(3, op, func),
                      refCtrl(4, op, func), tag);
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        retiredModel = 0;
    endtask

    initial begin
        logic [5:0] op;
        logic [3:0] func;

        vecs[0]  = '{6'h00, 4'h0, 24'h0, 24'h0, M_PCU | M_REGDEST | M_WRITEREG};
        vecs[1]  = '{6'h00, 4'h1, 24'h1, 24'h0, M_PCU | M_REGDEST | M_WRITEREG};
        vecs[2]  = '{6'h00, 4'h8, 24'h8, 24'h0, M_PCU | M_REGDEST | M_WRITEREG};
        vecs[3]  = '{6'h01, 4'h7, M_ALUSRC, 24'h0, M_PCU | M_WRITEREG};
        vecs[4]  = '{6'h02, 4'h0, M_ALUSRC | 24'h2, 24'h0, M_PCU | M_WRITEREG};
        vecs[5]  = '{6'h03, 4'h0, M_ALUSRC | 24'h3, 24'h0, M_PCU | M_WRITEREG};
        vecs[6]  = '{6'h04, 4'h0, M_ALUSRC, M_MEMREAD, M_PCU | M_MEMREG | M_WRITEREG};
        vecs[7]  = '{6'h05, 4'h0, M_ALUSRC, M_MEMWRITE, M_PCU};
        vecs[8]  = '{6'h06, 4'h0, 24'h0, 24'h0, M_PCU | M_MOVEREG | M_REGDEST | M_WRITEREG};
        vecs[9]  = '{6'h09, 4'h0, 24'h10, 24'h0, M_PCU};
        vecs[10] = '{6'h0A, 4'h0, 24'h20, 24'h0, M_PCU};
        vecs[11] = '{6'h0B, 4'h0, 24'h30, 24'h0, M_PCU};
        vecs[12] = '{6'h0C, 4'h0, 24'h0, 24'h0, M_PCU | M_JUMP};
        vecs[13] = '{6'h0D, 4'h0, M_READSP | M_SPMUX | M_PM4,
                     M_RETMEM | M_UPDATESP | M_MEMWRITE, M_PCU | M_WRITESP | M_JUMP};
        vecs[14] = '{6'h0E, 4'h0, M_READSP | M_SPMUX, M_MEMREAD,
                     M_PCU | M_MEMREG | M_RETPC | M_WRITESP};

        reset = 1'b1;
        instr = 32'h0;
        step();
        step();
        checkOutput("reset ctrl", {8'h0, ctrlVec()}, 32'h0);
        checkOutput("reset retired", retired, 32'h0);
        checkOutput("reset halted", {31'h0, halted}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++)
            applyStimulus(vecs[i].op, vecs[i].func, vecs[i].expExec, vecs[i].expMem,
                          vecs[i].expWb, $sformatf("vec%0d op%h", i, vecs[i].op));
        applyStimulus(6'h20, 4'h0, 24'h0, 24'h0, M_PCU, "illegal op20");

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0) op = knownOps[$urandom_range(0, 13)];
            else begin
                op = 6'($urandom);
                if (op == 6'h3F) op = 6'h2A;
            end
            func = 4'($urandom);
            runModel(op, func, $sformatf("rand%0d op%h", i, op));
        end

        // Reset while a store sits in EXEC must abandon it before MEM
        instr = {6'h05, 26'h0};
        step();
        step();
        reset = 1'b1;
        #1;
        checkOutput("rst-midST ctrl", {8'h0, ctrlVec()}, 32'h0);
        checkOutput("rst-midST retired", retired, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("rst-midST hold%0d memWrite", i), {31'h0, memWrite}, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        retiredModel = 0;
        applyStimulus(6'h00, 4'h0, 24'h0, 24'h0, M_PCU | M_REGDEST | M_WRITEREG, "post-rst ADD");

        doReset();
        for (int i = 0; i < 3; i++) runModel(knownOps[$urandom_range(0, 13)], 4'($urandom),
                                             $sformatf("pre-halt%0d", i));
        instr = {6'h3F, 26'h155};
        checkOutput("halt fetch ctrl", {8'h0, ctrlVec()}, 32'h0);
        step();
        checkOutput("halt decode ctrl", {8'h0, ctrlVec()}, 32'h0);
        step();
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("halt c%0d ctrl", i), {8'h0, ctrlVec()}, {8'h0, M_HALTPC});
            checkOutput($sformatf("halt c%0d halted", i), {31'h0, halted}, 32'h1);
            checkOutput($sformatf("halt c%0d retired", i), retired, 32'd3);
            instr = $urandom;
            step();
        end
        reset = 1'b1;
        #1;
        checkOutput("halt reset halted", {31'h0, halted}, 32'h0);
        checkOutput("halt reset ctrl", {8'h0, ctrlVec()}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit that sequences the single-datapath processor.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives every datapath control input from the current state and the latched opcode/func.
- Reads IM_out back from the datapath, and also provides halt status and a retired-instruction counter.

Parameters:
CNT_W, 32, width of the retired-instruction counter
HALT_OP, 6'h3F, opcode that halts the processor

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
instr  in  32  instruction word (datapath IM_out)
PCUpdate regDest writeSP readSP updateSP writeReg aluSource PM4 spmmux retMem memRead memWrite memReg spmux moveReg jump retPC haltPC  out  1 each  datapath controls
branch  out  2  branch condition select: 00 none, 01 zero, 10 negative, 11 positive
aluOp  out  4  ALU function
halted  out  1  high while in S_HALT
retired  out  CNT_W  instructions completed since reset

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset. It forces state=S_FETCH, op_q=0, func_q=0, retired=0, and all outputs to 0.
- Reset mid-instruction: the instruction in flight is abandoned with no further memWrite/writeReg.
- States: S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4, S_HALT=5.
  - Transitions are FETCH->DECODE->EXEC->MEM->WB->FETCH.
  - DECODE goes to HALT when instr[31:26]==HALT_OP.
  - HALT is absorbing until reset.
- Every non-halt instruction takes exactly 5 cycles.
- Opcode latch: op_q<=instr[31:26] and func_q<=instr[3:0] on the DECODE->next edge. Controls in EXEC/MEM/WB derive from op_q/func_q only.
- Outputs are combinational from (state, op_q, func_q). All outputs are 0 in any state/op combination not listed below.
- PCUpdate=1 only in S_WB. retired increments on that same edge and wraps modulo 2^CNT_W.
- aluOp codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SLA=6, SRA=7, SRL=8.
- Per-opcode control, by state (EXEC/MEM/WB):
  - 0x00 R-type: EXEC aluOp=func_q, aluSource=0. WB regDest=1, writeReg=1, memReg=0.
  - 0x01/0x02/0x03 ADDI/ANDI/ORI: EXEC aluSource=1, aluOp=ADD/AND/OR. WB regDest=0, writeReg=1.
  - 0x04 LD: EXEC aluSource=1, aluOp=ADD. MEM memRead=1. WB memReg=1, writeReg=1.
  - 0x05 ST: EXEC aluSource=1, aluOp=ADD. MEM memWrite=1.
  - 0x06 MOVE: WB moveReg=1, regDest=1, writeReg=1.
  - 0x09/0x0A/0x0B BZ/BLTZ/BGTZ: EXEC aluOp=ADD, aluSource=0, branch=01/10/11. branch stays 0 elsewhere.
  - 0x0C JUMP: WB jump=1.
  - 0x0D CALL:
    - EXEC readSP=1, spmux=1, PM4=1 (-1), aluOp=ADD.
    - MEM retMem=1, updateSP=1, memWrite=1.
    - WB writeSP=1, jump=1.
  - 0x0E RET:
    - EXEC readSP=1, spmux=1, PM4=0 (+1), aluOp=ADD.
    - MEM memRead=1.
    - WB memReg=1, retPC=1, writeSP=1.
- Unknown opcodes execute as a 5-cycle NOP: PCUpdate in WB, no writes.
- S_HALT: haltPC=1, halted=1, PCUpdate=0, memWrite=0, writeReg=0.
- spmmux is reserved: tied to 0.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE..OP_RET, HALT_OP default)
  - aluOp codes
  - branch codes
- One sub-module, ctrl_decode: a purely combinational (state, op_q, func_q) -> control-vector table.
- multicycle_ctrl keeps the FSM, the latches and the counter.

Test Plan:
- Reset during EXEC of ST (opcode 0x05): no memWrite in any cycle after reset; state=S_FETCH; retired=0; all outputs 0.
- R-type ADD (op 0x00, func 0): memWrite is never asserted.
  - EXEC: aluOp=0, aluSource=0.
  - WB: writeReg=1, regDest=1, PCUpdate=1.
  - retired becomes 1 after cycle 5.
- LD then ST back-to-back:
  - memRead only in cycle 4.
  - memWrite only in cycle 9.
  - memReg=1 in cycle 5.
  - retired=2 after cycle 10.
- CALL (0x0D):
  - EXEC readSP=1, spmux=1, PM4=1.
  - MEM retMem=1, updateSP=1, memWrite=1.
  - WB jump=1, writeSP=1, PCUpdate=1.
- BLTZ (0x0A): branch=10 only in EXEC, 00 otherwise. Illegal op 0x20: 5 cycles, only PCUpdate is high (in WB).
- HALT (0x3F) after 3 instructions:
  - halted=1 and haltPC=1 from cycle 3 of the halt onward.
  - PCUpdate stays 0 and retired stays 3 for 20 cycles.
  - reset clears halted.
